// File: rtl/decim_accumulator.sv
// Decimating accumulator: sums decim_len consecutive valid samples into one frame sum.
// Latency: 1 cycle from the frame's last accepted sample to valid_out (2 with DECIM_ACC_AVG_EN).
// Backpressure: none; every valid_in sample is consumed, and gaps in valid_in simply pause the frame.
//
// Optional build macro: DECIM_ACC_AVG_EN adds one output register stage that
// converts the frame sum into a rounded average: (sum + 2^(AVG_SHIFT-1)) >>> AVG_SHIFT.
//
// Ports:
//   clk          - single clock for the whole block
//   rst          - synchronous, active-high reset (priority over everything)
//   decim_len    - frame length in valid samples; 0 acts as 1, > MAX_DECIM acts as MAX_DECIM
//   frame_clear  - abort the current frame; a coincident sample is discarded
//   valid_in     - qualifier for data_in
//   data_in      - signed sample from the adder tree
//   data_out     - signed frame sum (or rounded average), held until the next result
//   valid_out    - one-cycle strobe marking a new data_out
//   frame_active - high while a frame is partially accumulated
module decim_accumulator #(
    parameter  int DATA_WIDTH = 19,
    parameter  int MAX_DECIM  = 1024,
    parameter  int AVG_SHIFT  = 10,
    localparam int CNT_WIDTH  = $clog2(MAX_DECIM) + 1,
    localparam int ACC_WIDTH  = DATA_WIDTH + $clog2(MAX_DECIM)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [CNT_WIDTH-1:0]  decim_len,
    input  logic                  frame_clear,
    input  logic                  valid_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [ACC_WIDTH-1:0]  data_out,
    output logic                  valid_out,
    output logic                  frame_active
);

    localparam logic [CNT_WIDTH-1:0] LEN_ONE = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] LEN_MAX = CNT_WIDTH'(MAX_DECIM);

    // The averaging shift may not exceed the accumulator growth bits; beyond
    // that the rounded result would no longer be a meaningful average.
    if (AVG_SHIFT < 0 || AVG_SHIFT > $clog2(MAX_DECIM)) begin : g_bad_shift
        $error("decim_accumulator: AVG_SHIFT out of range");
    end

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    state_t                 state_q,   state_d;
    logic [ACC_WIDTH-1:0]   acc_q,     acc_d;
    logic [CNT_WIDTH-1:0]   cnt_q,     cnt_d;
    logic [CNT_WIDTH-1:0]   len_lat_q, len_lat_d;
    logic [ACC_WIDTH-1:0]   sum_q,     sum_d;
    logic                   sum_vld_q, sum_vld_d;

    logic [CNT_WIDTH-1:0]   len_eff;
    logic [ACC_WIDTH-1:0]   sample_ext;
    logic [ACC_WIDTH-1:0]   acc_sum;
    logic [CNT_WIDTH-1:0]   cnt_inc;
    logic                   last_smp;

    // Frame length as seen by a frame starting this cycle.
    always_comb begin
        len_eff = decim_len;
        if (decim_len == '0) begin
            len_eff = LEN_ONE;
        end else if (decim_len > LEN_MAX) begin
            len_eff = LEN_MAX;
        end
    end

    // Sign-extend before adding; ACC_WIDTH leaves log2(MAX_DECIM) guard bits,
    // so a full frame of full-scale samples cannot wrap.
    always_comb begin
        sample_ext = {{(ACC_WIDTH - DATA_WIDTH){data_in[DATA_WIDTH-1]}}, data_in};
        acc_sum    = acc_q + sample_ext;
        cnt_inc    = cnt_q + LEN_ONE;
        // >= rather than == so a frame can never run past its latched length.
        last_smp   = (cnt_inc >= len_lat_q);
    end

    // Next-state / datapath.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        len_lat_d = len_lat_q;
        sum_d     = sum_q;
        sum_vld_d = 1'b0;

        if (frame_clear) begin
            // Clear wins over a coincident sample, including a completing one.
            state_d = IDLE;
            acc_d   = '0;
            cnt_d   = '0;
        end else if (valid_in) begin
            case (state_q)
                IDLE: begin
                    len_lat_d = len_eff;
                    if (len_eff == LEN_ONE) begin
                        // Single-sample frames bypass the accumulator.
                        sum_d     = sample_ext;
                        sum_vld_d = 1'b1;
                    end else begin
                        acc_d   = sample_ext;
                        cnt_d   = LEN_ONE;
                        state_d = ACCUM;
                    end
                end
                ACCUM: begin
                    if (last_smp) begin
                        sum_d     = acc_sum;
                        sum_vld_d = 1'b1;
                        acc_d     = '0;
                        cnt_d     = '0;
                        state_d   = IDLE;
                    end else begin
                        acc_d = acc_sum;
                        cnt_d = cnt_inc;
                    end
                end
                default: begin
                    state_d = IDLE;
                    acc_d   = '0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            cnt_q     <= '0;
            len_lat_q <= '0;
            sum_q     <= '0;
            sum_vld_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            len_lat_q <= len_lat_d;
            sum_q     <= sum_d;
            sum_vld_q <= sum_vld_d;
        end
    end

    assign frame_active = (state_q == ACCUM);

`ifdef DECIM_ACC_AVG_EN
    // Round half toward +inf, then arithmetic shift. The rounding constant is
    // at most MAX_DECIM/2 and the largest positive sum is at least MAX_DECIM
    // below the ACC_WIDTH ceiling, so the addition cannot overflow.
    localparam logic [ACC_WIDTH-1:0] RND_C =
        (AVG_SHIFT == 0) ? '0
                         : (ACC_WIDTH'(1) << ((AVG_SHIFT == 0) ? 0 : (AVG_SHIFT - 1)));

    logic signed [ACC_WIDTH-1:0] rnd_sum;
    logic [ACC_WIDTH-1:0]        avg_q, avg_d;
    logic                        avg_vld_q, avg_vld_d;

    always_comb begin
        rnd_sum   = $signed(sum_q + RND_C);
        avg_vld_d = sum_vld_q;
        avg_d     = avg_q;
        if (sum_vld_q) begin
            avg_d = rnd_sum >>> AVG_SHIFT;
        end
    end

    // This stage is independent of frame_clear: a finished frame always emerges.
    always_ff @(posedge clk) begin
        if (rst) begin
            avg_q     <= '0;
            avg_vld_q <= 1'b0;
        end else begin
            avg_q     <= avg_d;
            avg_vld_q <= avg_vld_d;
        end
    end

    assign data_out  = avg_q;
    assign valid_out = avg_vld_q;
`else
    assign data_out  = sum_q;
    assign valid_out = sum_vld_q;
`endif

endmodule

// File: tb/tb_decim_accumulator.sv
module tb_decim_accumulator;

    localparam int DW   = 19;
    localparam int MAXD = 1024;
    localparam int SH   = 2;
    localparam int CW   = 11;
    localparam int AW   = 29;
`ifdef DECIM_ACC_AVG_EN
    localparam int LAT  = 2;
`else
    localparam int LAT  = 1;
`endif

    logic          clk;
    logic          rst;
    logic [CW-1:0] decim_len;
    logic          frame_clear;
    logic          valid_in;
    logic [DW-1:0] data_in;
    logic [AW-1:0] data_out;
    logic          valid_out;
    logic          frame_active;

    decim_accumulator #(
        .DATA_WIDTH (DW),
        .MAX_DECIM  (MAXD),
        .AVG_SHIFT  (SH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .decim_len    (decim_len),
        .frame_clear  (frame_clear),
        .valid_in     (valid_in),
        .data_in      (data_in),
        .data_out     (data_out),
        .valid_out    (valid_out),
        .frame_active (frame_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        longint val;
        int     cyc;
    } exp_t;

    exp_t   sb[$];
    longint obs[$];
    int     vectors;
    int     miscompares;
    int     cyc;

    // Reference model state
    bit     m_accum;
    longint m_acc;
    int     m_cnt;
    int     m_len;
    int     m_pushes;
    longint exp_dout;

    function automatic longint post(longint s);
`ifdef DECIM_ACC_AVG_EN
        longint t;
        t = s;
        if (SH > 0) t = t + (longint'(1) <<< (SH - 1));
        return t >>> SH;
`else
        return s;
`endif
    endfunction

    task automatic chk(input string tag, input longint got, input longint exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic push(input longint s);
        exp_t e;
        e.val = post(s);
        e.cyc = cyc + LAT - 1;
        sb.push_back(e);
        m_pushes++;
    endtask

    task automatic model_edge(input bit r, input bit c, input bit v,
                              input logic [DW-1:0] d, input logic [CW-1:0] len);
        longint sx;
        int     le;
        sx = longint'($signed(d));
        if (len == 0)         le = 1;
        else if (len > MAXD)  le = MAXD;
        else                  le = int'(len);
        if (r) begin
            m_accum = 0; m_acc = 0; m_cnt = 0; m_len = 0;
            sb.delete();
            exp_dout = 0;
        end else if (c) begin
            m_accum = 0; m_acc = 0; m_cnt = 0;
        end else if (v) begin
            if (!m_accum) begin
                m_len = le;
                if (le == 1) push(sx);
                else begin
                    m_acc = sx; m_cnt = 1; m_accum = 1;
                end
            end else if (m_cnt + 1 == m_len) begin
                push(m_acc + sx);
                m_accum = 0; m_acc = 0; m_cnt = 0;
            end else begin
                m_acc = m_acc + sx;
                m_cnt = m_cnt + 1;
            end
        end
    endtask

    task automatic check_outputs();
        bit   exp_v;
        exp_t e;
        exp_v = (sb.size() > 0) && (sb[0].cyc == cyc);
        chk("valid_out", longint'(valid_out), longint'(exp_v));
        if (exp_v) begin
            e = sb.pop_front();
            chk("data_out", longint'($signed(data_out)), e.val);
            exp_dout = e.val;
            if (valid_out === 1'b1) obs.push_back(longint'($signed(data_out)));
        end else begin
            chk("data_out_hold", longint'($signed(data_out)), exp_dout);
        end
        chk("frame_active", longint'(frame_active), longint'(m_accum));
    endtask

    // Drive at the falling edge, model the rising edge, check at the next falling edge.
    task automatic tick(input bit r, input bit c, input bit v, input logic [DW-1:0] d);
        rst         = r;
        frame_clear = c;
        valid_in    = v;
        data_in     = d;
        @(posedge clk);
        cyc++;
        model_edge(r, c, v, d, decim_len);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic smp(input int x);
        tick(1'b0, 1'b0, 1'b1, DW'(x));
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick(1'b0, 1'b0, 1'b0, '0);
    endtask

    int          basic[8] = '{1, 2, 3, 4, -5, -6, 7, 8};
    int          p0;
    bit [31:0]   rnd;

    initial begin
        vectors = 0; miscompares = 0; cyc = 0;
        m_accum = 0; m_acc = 0; m_cnt = 0; m_len = 0; m_pushes = 0; exp_dout = 0;
        rst = 1'b1; frame_clear = 1'b0; valid_in = 1'b0; data_in = '0; decim_len = '0;
        @(negedge clk);

        // Reset held with valid_in high: nothing may come out
        decim_len = 11'd1;
        repeat (5) tick(1'b1, 1'b0, 1'b1, DW'(7));

        // Basic back-to-back frames of 4
        decim_len = 11'd4;
        obs.delete();
        foreach (basic[i]) smp(basic[i]);
        idle(3);
        chk("basic_count", obs.size(), 2);
        chk("basic_frame0", obs[0], post(10));
        chk("basic_frame1", obs[1], post(4));

        // Gaps with a mid-frame length change; next frame uses the new length
        decim_len = 11'd3;
        obs.delete();
        smp(100);
        decim_len = 11'd7;
        idle(2);
        smp(-300);
        idle(1);
        smp(50);
        idle(2);
        chk("gap_count", obs.size(), 1);
        chk("gap_sum", obs[0], post(-150));
        repeat (7) smp(1);
        idle(2);
        chk("len7_count", obs.size(), 2);
        chk("len7_sum", obs[1], post(7));

        // Length 0 and 1 both pass every sample through
        decim_len = 11'd0;
        obs.delete();
        repeat (3) smp(-32);
        decim_len = 11'd1;
        repeat (3) smp(-32);
        idle(2);
        chk("pass_count", obs.size(), 6);
        chk("pass_first", obs[0], post(-32));
        chk("pass_last", obs[5], post(-32));

        // Oversized length clamps to MAX_DECIM
        decim_len = 11'd2047;
        obs.delete();
        repeat (1024) smp(1);
        idle(2);
        chk("clamp_count", obs.size(), 1);
        chk("clamp_sum", obs[0], post(1024));

        // Full-scale negative frame must not wrap
        decim_len = 11'd1024;
        obs.delete();
        repeat (1024) smp(-(1 << 18));
        idle(2);
        chk("fullscale_count", obs.size(), 1);
        chk("fullscale_sum", obs[0], post(-(longint'(1) <<< 28)));

        // Clear coincident with the completing sample suppresses the output
        decim_len = 11'd4;
        obs.delete();
        repeat (3) smp(5);
        tick(1'b0, 1'b1, 1'b1, DW'(5));
        repeat (4) smp(1);
        idle(2);
        chk("clear_count", obs.size(), 1);
        chk("clear_next", obs[0], post(4));

        // Reset mid-frame discards the partial sum
        decim_len = 11'd3;
        obs.delete();
        smp(9);
        smp(9);
        tick(1'b1, 1'b0, 1'b1, DW'(9));
        repeat (3) smp(2);
        idle(2);
        chk("rst_mid_count", obs.size(), 1);
        chk("rst_mid_sum", obs[0], post(6));

`ifdef DECIM_ACC_AVG_EN
        // Rounded averages; a clear right after completion does not cancel the result
        decim_len = 11'd4;
        obs.delete();
        smp(1); smp(1); smp(1); smp(3);
        tick(1'b0, 1'b1, 1'b0, '0);
        idle(1);
        smp(-1); smp(-1); smp(-1); smp(-3);
        idle(2);
        chk("avg_count", obs.size(), 2);
        chk("avg_pos", obs[0], 2);
        chk("avg_neg", obs[1], -1);
`endif

        // Random frames: 30% invalid duty, occasional length changes and clears
        p0 = m_pushes;
        for (int i = 0; i < 20000 && (m_pushes - p0) < 200; i++) begin
            if ($urandom_range(0, 19) == 0) decim_len = CW'($urandom_range(0, 9));
            rnd = $urandom();
            tick(1'b0, ($urandom_range(0, 99) < 2), ($urandom_range(0, 99) >= 30), rnd[DW-1:0]);
        end
        idle(3);
        chk("random_frames", longint'((m_pushes - p0) >= 200), 1);
        chk("queue_empty", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/decim_accumulator.md
Name: decim_accumulator

Overview:
- Downstream consumer of the pipelined adder tree.
- Takes the tree's signed sum stream (data + valid) and accumulates a runtime-programmable number of consecutive valid samples into one frame sum.
- Emits one output per frame, which decimates the rate by decim_len.
- Feeds the per-turn/per-bunch averaging and readout logic.

Parameters:
- DATA_WIDTH, 19: width of the signed input sample (the adder tree output width, 16+3 for 8 inputs).
- MAX_DECIM, 1024: largest supported frame length in samples.
- AVG_SHIFT, 10: right-shift applied when the averaging option is compiled in; must be ≤ $clog2(MAX_DECIM).
- Derived, not overridable: CNT_WIDTH = $clog2(MAX_DECIM)+1.
- Derived, not overridable: ACC_WIDTH = DATA_WIDTH + $clog2(MAX_DECIM).

Ports:
- clk, input, 1: single clock for the whole block.
- rst, input, 1: synchronous, active-high reset.
- decim_len, input, CNT_WIDTH: frame length in valid samples.
- frame_clear, input, 1: abort the current frame.
- valid_in, input, 1: data_in qualifier.
- data_in, input, DATA_WIDTH: signed sample.
- data_out, output, ACC_WIDTH: signed frame sum, or average with the option.
- valid_out, output, 1: one-cycle strobe for data_out.
- frame_active, output, 1: high while a frame is partially accumulated.

Behaviour:
- Interface (decided): one clock, clk; reset rst is synchronous and active-high.
- Reset: acc=0, cnt=0, len_lat=0, state IDLE, data_out=0, valid_out=0, frame_active=0. Reset mid-frame discards the partial sum; no output is produced.
- Arithmetic:
  - data_in is sign-extended to ACC_WIDTH before addition.
  - Two's-complement accumulation, no saturation.
  - Width is sized so that MAX_DECIM full-scale samples cannot overflow.
- decim_len handling:
  - Clamped: 0 is treated as 1; values > MAX_DECIM are treated as MAX_DECIM.
  - Latched into len_lat only on the first accepted sample of a frame.
  - Changes mid-frame are ignored until the next frame.
- State machine, 2 states:
  - IDLE, valid_in=1, effective len=1: output data_out = sext(data_in); stay IDLE.
  - IDLE, valid_in=1, len>1: acc=sext(data_in), cnt=1, latch len, go to ACCUM.
  - ACCUM, valid_in=1, cnt+1 < len_lat: acc += sample, cnt++.
  - ACCUM, valid_in=1, cnt+1 == len_lat: data_out <= acc + sample, valid_out <= 1; acc=0, cnt=0, go to IDLE.
  - valid_in=0 in either state: hold everything. Gaps of any length are allowed; the frame counts valid samples, not cycles.
- Latency: valid_out asserts on the clock edge after the one that accepted the frame's last sample (1 cycle).
- Back-to-back frames are supported with no dead cycle. The sample following a completing sample starts a new frame in IDLE.
- Output hold: valid_out is a single-cycle pulse. data_out holds its last value until the next output.
- frame_active = (state == ACCUM).
- frame_clear:
  - Synchronous, has priority over valid_in.
  - Effect: acc=0, cnt=0, go to IDLE, no valid_out.
  - A sample coincident with frame_clear is discarded.
  - A clear on the same cycle as a completing sample suppresses that output.
- rst has priority over frame_clear and valid_in.

Optional Feature:
- Macro: DECIM_ACC_AVG_EN.
- Defined:
  - One extra output register stage.
  - data_out = (sum + 2^(AVG_SHIFT-1)) >>> AVG_SHIFT: arithmetic shift, round half toward +inf, sign-extended to ACC_WIDTH.
  - Latency becomes 2 cycles; valid_out is delayed to match.
  - If AVG_SHIFT = 0, no rounding constant is added.
  - Reset clears the extra stage.
  - frame_clear does not cancel a result already in the extra stage.
- Undefined: raw sum, 1-cycle latency, no extra registers.

Test Plan:
- Reset check: hold rst 5 cycles with valid_in=1 -> valid_out=0, data_out=0, frame_active=0 throughout.
- Basic frame: decim_len=4, continuous valid, data 1,2,3,4,-5,-6,7,8 -> valid_out pulses 1 cycle after samples 4 and 8; data_out=10 then 4; frame_active=0 between frames.
- Gaps plus length change: decim_len=3; valid pattern 1,0,0,1,0,1 with data 100,-,-,-300,-,50; change decim_len to 7 after the first sample -> single output -150, latched length 3 respected. Next frame uses 7.
- Clamps and pass-through: decim_len=0, then 1, data -32 -> an output every valid cycle equal to -32 sign-extended. decim_len=2047 with MAX_DECIM=1024 -> output after 1024 samples.
- Full-scale overflow: decim_len=1024, data=-2^18 every cycle -> data_out=-2^28 exactly, with no wrap.
- Clear: decim_len=4, samples 5,5,5, then frame_clear coincident with a 4th sample -> no valid_out. The next 4 samples of 1 -> output 4.
- Averaging (with DECIM_ACC_AVG_EN): AVG_SHIFT=2, decim_len=4, data 1,1,1,3 -> output 2 at 2-cycle latency. Data -1,-1,-1,-3 -> output -1. Random 200-frame scoreboard vs model with a 30% invalid duty -> 0 errors, empty queue at end.
